// File: rtl/mc_ctrl.sv
// Multi-cycle control sequencer for the RV32I core: steps IF/ID/EX/MEM/WB,
// drives register/memory strobes, counts retired instructions, traps on faults.
module mc_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        ir_we,
  output logic        pc_we,
  output logic        rf_we,
  output logic        retire,
  output logic [31:0] instret,
  output logic [2:0]  state,
  output logic        halt,
  output logic [1:0]  trap_cause
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_TRAP = 3'd7
  } state_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_IMEM    = 2'd2;
  localparam logic [1:0] CAUSE_DMEM    = 2'd3;

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [1:0]        trap_cause_q, trap_cause_d;
  logic [31:0]       instret_q, instret_d;
  logic              is_store_q, is_store_d;

  logic op_legal, op_branch, op_load, op_store;
  logic imem_req_c, ir_we_c, dmem_req_c, dmem_we_c, pc_we_c, rf_we_c, retire_c;

  always_comb begin
    op_branch = (opcode == OPC_BRANCH);
    op_load   = (opcode == OPC_LOAD);
    op_store  = (opcode == OPC_STORE);
    op_legal  = (opcode == OPC_LUI)   || (opcode == OPC_AUIPC) ||
                (opcode == OPC_JAL)   || (opcode == OPC_JALR)  ||
                (opcode == OPC_OPIMM) || (opcode == OPC_OP)    ||
                op_branch || op_load || op_store;
  end

  // Handshake: a request is held high for every cycle of its state; the
  // matching ack completes it on the rising edge where both are high. Acks
  // seen in any other state are ignored.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    trap_cause_d = trap_cause_q;
    is_store_d   = is_store_q;
    imem_req_c   = 1'b0;
    ir_we_c      = 1'b0;
    dmem_req_c   = 1'b0;
    dmem_we_c    = 1'b0;
    pc_we_c      = 1'b0;
    rf_we_c      = 1'b0;
    retire_c     = 1'b0;

    case (state_q)
      S_IF: begin
        imem_req_c = 1'b1;
        ir_we_c    = imem_ack;
        if (imem_ack) begin
          state_d    = S_ID;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d      = S_TRAP;
          trap_cause_d = CAUSE_IMEM;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      S_ID: begin
        if (!op_legal) begin
          state_d      = S_TRAP;
          trap_cause_d = CAUSE_ILLEGAL;
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        // MEM must not look at opcode again, so the access direction is kept.
        is_store_d = op_store;
        if (op_load || op_store) begin
          state_d    = S_MEM;
          wait_cnt_d = '0;
        end else if (op_branch) begin
          pc_we_c    = 1'b1;
          retire_c   = 1'b1;
          state_d    = S_IF;
          wait_cnt_d = '0;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_req_c = 1'b1;
        dmem_we_c  = is_store_q;
        if (dmem_ack) begin
          wait_cnt_d = '0;
          if (is_store_q) begin
            pc_we_c  = 1'b1;
            retire_c = 1'b1;
            state_d  = S_IF;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d      = S_TRAP;
          trap_cause_d = CAUSE_DMEM;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      S_WB: begin
        rf_we_c    = 1'b1;
        pc_we_c    = 1'b1;
        retire_c   = 1'b1;
        state_d    = S_IF;
        wait_cnt_d = '0;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d    = S_IF;
        wait_cnt_d = '0;
      end
    endcase

    instret_d = retire_c ? instret_q + 32'd1 : instret_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IF;
      wait_cnt_q   <= '0;
      trap_cause_q <= 2'd0;
      instret_q    <= 32'd0;
      is_store_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      trap_cause_q <= trap_cause_d;
      instret_q    <= instret_d;
      is_store_q   <= is_store_d;
    end
  end

  // Reset is asynchronous, so strobes are masked by rst directly.
  assign imem_req   = imem_req_c & ~rst;
  assign ir_we      = ir_we_c    & ~rst;
  assign dmem_req   = dmem_req_c & ~rst;
  assign dmem_we    = dmem_we_c  & ~rst;
  assign pc_we      = pc_we_c    & ~rst;
  assign rf_we      = rf_we_c    & ~rst;
  assign retire     = retire_c   & ~rst;
  assign halt       = (state_q == S_TRAP) & ~rst;
  assign state      = state_q;
  assign instret    = instret_q;
  assign trap_cause = trap_cause_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: walks each instruction class, ack waits,
// both timeouts, illegal opcode and mid-instruction reset.
module tb_mc_ctrl;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_BAD    = 7'b0000000;

  // {imem_req, ir_we, dmem_req, dmem_we, pc_we, rf_we, retire, halt}
  localparam logic [7:0] B_NONE   = 8'h00;
  localparam logic [7:0] B_IF     = 8'h80;
  localparam logic [7:0] B_IF_ACK = 8'hC0;
  localparam logic [7:0] B_MEM_LD = 8'h20;
  localparam logic [7:0] B_MEM_ST = 8'h3A;
  localparam logic [7:0] B_BR_EX  = 8'h0A;
  localparam logic [7:0] B_WB     = 8'h0E;
  localparam logic [7:0] B_TRAP   = 8'h01;

  logic        clk, rst;
  logic [6:0]  opcode;
  logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack;
  logic        ir_we, pc_we, rf_we, retire, halt;
  logic [31:0] instret;
  logic [2:0]  state;
  logic [1:0]  trap_cause;
  logic [7:0]  strb;

  int compared   = 0;
  int mismatched = 0;

  mc_ctrl #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .opcode(opcode),
    .imem_req(imem_req), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .ir_we(ir_we), .pc_we(pc_we), .rf_we(rf_we), .retire(retire),
    .instret(instret), .state(state), .halt(halt), .trap_cause(trap_cause)
  );

  assign strb = {imem_req, ir_we, dmem_req, dmem_we, pc_we, rf_we, retire, halt};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs are set at a falling edge; outputs are checked 1 time unit later.
  task automatic step(input string tag, input logic [2:0] es, input logic [7:0] eb);
    #1;
    chk({tag, "_state"}, {29'd0, state}, {29'd0, es});
    chk({tag, "_strb"}, {24'd0, strb}, {24'd0, eb});
    @(negedge clk);
  endtask

  task automatic run_op(input string tag);
    opcode   = OP_OP;
    imem_ack = 1'b1;
    step({tag, "_if"}, 3'd0, B_IF_ACK);
    step({tag, "_id"}, 3'd1, B_NONE);
    step({tag, "_ex"}, 3'd2, B_NONE);
    step({tag, "_wb"}, 3'd4, B_WB);
  endtask

  initial begin
    rst      = 1'b1;
    opcode   = OP_OP;
    imem_ack = 1'b1;
    dmem_ack = 1'b1;
    @(negedge clk);

    step("rst", 3'd0, B_NONE);
    chk("rst_instret", instret, 32'd0);
    chk("rst_cause", {30'd0, trap_cause}, 32'd0);
    rst      = 1'b0;
    dmem_ack = 1'b0;

    for (int k = 0; k < 3; k++) begin
      chk("op_instret", instret, k);
      run_op("op");
    end
    chk("op_instret3", instret, 32'd3);

    opcode = OP_LOAD;
    step("ld_if", 3'd0, B_IF_ACK);
    step("ld_id", 3'd1, B_NONE);
    step("ld_ex", 3'd2, B_NONE);
    step("ld_mem0", 3'd3, B_MEM_LD);
    step("ld_mem1", 3'd3, B_MEM_LD);
    dmem_ack = 1'b1;
    step("ld_mem2", 3'd3, B_MEM_LD);
    dmem_ack = 1'b0;
    step("ld_wb", 3'd4, B_WB);
    chk("ld_instret", instret, 32'd4);

    opcode = OP_STORE;
    step("st_if", 3'd0, B_IF_ACK);
    step("st_id", 3'd1, B_NONE);
    step("st_ex", 3'd2, B_NONE);
    dmem_ack = 1'b1;
    step("st_mem", 3'd3, B_MEM_ST);
    dmem_ack = 1'b0;
    chk("st_instret", instret, 32'd5);

    opcode = OP_BRANCH;
    step("br_if", 3'd0, B_IF_ACK);
    step("br_id", 3'd1, B_NONE);
    step("br_ex", 3'd2, B_BR_EX);
    chk("br_instret", instret, 32'd6);

    opcode   = OP_OP;
    imem_ack = 1'b0;
    step("iw_if0", 3'd0, B_IF);
    step("iw_if1", 3'd0, B_IF);
    step("iw_if2", 3'd0, B_IF);
    imem_ack = 1'b1;
    step("iw_if3", 3'd0, B_IF_ACK);
    step("iw_id", 3'd1, B_NONE);
    step("iw_ex", 3'd2, B_NONE);
    step("iw_wb", 3'd4, B_WB);
    chk("iw_instret", instret, 32'd7);

    imem_ack = 1'b0;
    for (int i = 0; i < 4; i++) step("ito_if", 3'd0, B_IF);
    step("ito_trap", 3'd7, B_TRAP);
    chk("ito_cause", {30'd0, trap_cause}, 32'd2);
    chk("ito_instret", instret, 32'd7);

    rst = 1'b1;
    step("rst2", 3'd0, B_NONE);
    chk("rst2_instret", instret, 32'd0);
    chk("rst2_cause", {30'd0, trap_cause}, 32'd0);
    rst      = 1'b0;
    imem_ack = 1'b1;

    opcode = OP_LOAD;
    step("dto_if", 3'd0, B_IF_ACK);
    step("dto_id", 3'd1, B_NONE);
    step("dto_ex", 3'd2, B_NONE);
    for (int i = 0; i < 4; i++) step("dto_mem", 3'd3, B_MEM_LD);
    step("dto_trap", 3'd7, B_TRAP);
    chk("dto_cause", {30'd0, trap_cause}, 32'd3);

    rst = 1'b1;
    step("rst3", 3'd0, B_NONE);
    rst = 1'b0;

    run_op("pre_ill");
    chk("pre_ill_instret", instret, 32'd1);
    opcode = OP_BAD;
    step("ill_if", 3'd0, B_IF_ACK);
    step("ill_id", 3'd1, B_NONE);
    for (int i = 0; i < 4; i++) begin
      imem_ack = i[0];
      dmem_ack = ~i[0];
      step("ill_trap", 3'd7, B_TRAP);
      chk("ill_cause", {30'd0, trap_cause}, 32'd1);
    end
    dmem_ack = 1'b0;
    rst      = 1'b1;
    step("rst4", 3'd0, B_NONE);
    chk("rst4_instret", instret, 32'd0);
    chk("rst4_cause", {30'd0, trap_cause}, 32'd0);
    rst      = 1'b0;
    imem_ack = 1'b1;

    run_op("pre_mid");
    chk("pre_mid_instret", instret, 32'd1);
    opcode = OP_OP;
    step("mid_if", 3'd0, B_IF_ACK);
    step("mid_id", 3'd1, B_NONE);
    step("mid_ex", 3'd2, B_NONE);
    rst = 1'b1;
    step("mid_rst", 3'd0, B_NONE);
    chk("mid_instret", instret, 32'd0);
    rst = 1'b0;
    step("post_if", 3'd0, B_IF_ACK);
    step("post_id", 3'd1, B_NONE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
